// File: rtl/hsv_core_mem_tracker_if.sv
// Handshake bundle between the dmem request/response stages and the outstanding-transaction tracker.
// The master side drives events and the flush request; the slave side is the tracker itself.
interface hsv_core_mem_tracker_if #(
   parameter int CNT_WIDTH = 4
);
   logic                 flush_req;
   logic                 flush;
   logic                 flush_ack;
   logic                 read_issue;
   logic                 read_done;
   logic                 write_issue;
   logic                 write_done;
   logic                 write_fwd;
   logic                 commit_write;
   logic                 can_issue_read;
   logic                 can_issue_write;
   logic [CNT_WIDTH-1:0] pending_reads;
   logic [CNT_WIDTH-1:0] pending_writes;
   logic [CNT_WIDTH-1:0] write_balance;
   logic                 idle;
   logic                 err;

   modport master (
      output flush_req, read_issue, read_done, write_issue, write_done, write_fwd, commit_write,
      input  flush, flush_ack, can_issue_read, can_issue_write,
             pending_reads, pending_writes, write_balance, idle, err
   );

   modport slave (
      input  flush_req, read_issue, read_done, write_issue, write_done, write_fwd, commit_write,
      output flush, flush_ack, can_issue_read, can_issue_write,
             pending_reads, pending_writes, write_balance, idle, err
   );
endinterface

// File: rtl/hsv_core_mem_tracker.sv
// Outstanding dmem read/write tracker with issue limits, read/write ordering and a drain-then-flush sequencer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RST   | just out of reset; flush and flush_ack both asserted
// ST_RUN   | normal operation, issues permitted within limits
// ST_DRAIN | flush requested; no new issues, waiting for counters to reach zero
// ST_FLUSH | one-cycle flush pulse; counters cleared on this edge
// ST_HOLD  | flush_ack asserted until commit drops flush_req
module hsv_core_mem_tracker #(
   parameter int CNT_WIDTH    = 4,
   parameter int MAX_READS    = 8,
   parameter int MAX_WRITES   = 8,
   parameter bit STRICT_ORDER = 1'b1
) (
   input logic                  clk_core,
   input logic                  rst_core_n,
   hsv_core_mem_tracker_if.slave trk
);

   typedef enum logic [2:0] {
      ST_RST   = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_FLUSH = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONES = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] BAL_MAX  = {1'b0, {(CNT_WIDTH-1){1'b1}}};
   localparam logic [CNT_WIDTH-1:0] BAL_MIN  = {1'b1, {(CNT_WIDTH-1){1'b0}}};
   localparam logic [CNT_WIDTH-1:0] MAX_R    = CNT_WIDTH'(MAX_READS);
   localparam logic [CNT_WIDTH-1:0] MAX_W    = CNT_WIDTH'(MAX_WRITES);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
   logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
   logic [CNT_WIDTH-1:0] bal_q, bal_d;
   logic                 err_q, err_d;

   logic                 idle_w;
   logic                 run_w;
   logic                 flush_w;
   logic                 flush_ack_w;
   logic                 rd_ok_w;
   logic                 wr_ok_w;
   logic                 bal_pos_w;
   logic [CNT_WIDTH:0]   rd_step_w;
   logic [CNT_WIDTH:0]   wr_step_w;
   logic [CNT_WIDTH:0]   bal_step_w;

   // Returns {misuse, next}; a saturating step holds the value and flags misuse.
   function automatic logic [CNT_WIDTH:0] step_cnt(
      input logic [CNT_WIDTH-1:0] cur,
      input logic                 inc,
      input logic                 dec,
      input logic [CNT_WIDTH-1:0] top,
      input logic [CNT_WIDTH-1:0] bottom
   );
      logic                 bad;
      logic [CNT_WIDTH-1:0] nxt;
      bad = 1'b0;
      nxt = cur;
      if (inc && !dec) begin
         if (cur == top) bad = 1'b1;
         else            nxt = cur + 1'b1;
      end else if (dec && !inc) begin
         if (cur == bottom) bad = 1'b1;
         else               nxt = cur - 1'b1;
      end
      return {bad, nxt};
   endfunction

   assign idle_w    = (rd_cnt_q == '0) && (wr_cnt_q == '0) && (bal_q == '0);
   assign bal_pos_w = !bal_q[CNT_WIDTH-1] && (bal_q != '0);

   always_comb begin
      state_d     = state_q;
      run_w       = 1'b0;
      flush_w     = 1'b0;
      flush_ack_w = 1'b0;
      case (state_q)
         ST_RST: begin
            flush_w     = 1'b1;
            flush_ack_w = 1'b1;
            state_d     = trk.flush_req ? ST_HOLD : ST_RUN;
         end
         ST_RUN: begin
            run_w = 1'b1;
            if (trk.flush_req) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!trk.flush_req) state_d = ST_RUN;
            else if (idle_w)    state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            flush_w = 1'b1;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            flush_ack_w = 1'b1;
            if (!trk.flush_req) state_d = ST_RUN;
         end
         default: state_d = ST_RST;
      endcase
   end

   // In strict mode a read permit suppresses the write permit, so a read wins a tie.
   always_comb begin
      rd_ok_w = run_w && (rd_cnt_q < MAX_R);
      wr_ok_w = run_w && (wr_cnt_q < MAX_W) && (bal_pos_w || trk.commit_write);
      if (STRICT_ORDER) begin
         rd_ok_w = rd_ok_w && (wr_cnt_q == '0) && !trk.write_issue;
         wr_ok_w = wr_ok_w && (rd_cnt_q == '0) && !trk.read_issue && !rd_ok_w;
      end
   end

   always_comb begin
      rd_step_w  = step_cnt(rd_cnt_q, trk.read_issue, trk.read_done, CNT_ONES, '0);
      wr_step_w  = step_cnt(wr_cnt_q, trk.write_issue, trk.write_done, CNT_ONES, '0);
      bal_step_w = step_cnt(bal_q, trk.write_fwd, trk.write_issue, BAL_MAX, BAL_MIN);
      rd_cnt_d   = rd_step_w[CNT_WIDTH-1:0];
      wr_cnt_d   = wr_step_w[CNT_WIDTH-1:0];
      bal_d      = bal_step_w[CNT_WIDTH-1:0];
      err_d      = err_q | rd_step_w[CNT_WIDTH] | wr_step_w[CNT_WIDTH] | bal_step_w[CNT_WIDTH];
      if (state_q == ST_FLUSH) begin
         // Events during the flush cycle are dropped; only flag them if they hit live state.
         rd_cnt_d = '0;
         wr_cnt_d = '0;
         bal_d    = '0;
         err_d    = err_q
                  | ((trk.read_issue  | trk.read_done)  & (rd_cnt_q != '0))
                  | ((trk.write_issue | trk.write_done) & (wr_cnt_q != '0))
                  | (trk.write_issue & (bal_q != '0));
      end
   end

   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         state_q  <= ST_RST;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         bal_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         bal_q    <= bal_d;
         err_q    <= err_d;
      end
   end

   assign trk.flush           = flush_w;
   assign trk.flush_ack       = flush_ack_w;
   assign trk.can_issue_read  = rd_ok_w;
   assign trk.can_issue_write = wr_ok_w;
   assign trk.pending_reads   = rd_cnt_q;
   assign trk.pending_writes  = wr_cnt_q;
   assign trk.write_balance   = bal_q;
   assign trk.idle            = idle_w;
   assign trk.err             = err_q;

endmodule

// File: tb/tb_hsv_core_mem_tracker.sv
// Directed bench for the mem tracker: a strict-order and a relaxed-order instance share one stimulus stream.
module tb_hsv_core_mem_tracker;

   logic clk_core;
   logic rst_core_n;
   logic flush_req, read_issue, read_done, write_issue, write_done, write_fwd, commit_write;

   int checks;
   int failures;

   hsv_core_mem_tracker_if #(.CNT_WIDTH(4)) if_s ();
   hsv_core_mem_tracker_if #(.CNT_WIDTH(4)) if_r ();

   assign if_s.flush_req    = flush_req;
   assign if_s.read_issue   = read_issue;
   assign if_s.read_done    = read_done;
   assign if_s.write_issue  = write_issue;
   assign if_s.write_done   = write_done;
   assign if_s.write_fwd    = write_fwd;
   assign if_s.commit_write = commit_write;
   assign if_r.flush_req    = flush_req;
   assign if_r.read_issue   = read_issue;
   assign if_r.read_done    = read_done;
   assign if_r.write_issue  = write_issue;
   assign if_r.write_done   = write_done;
   assign if_r.write_fwd    = write_fwd;
   assign if_r.commit_write = commit_write;

   hsv_core_mem_tracker #(
      .CNT_WIDTH(4), .MAX_READS(8), .MAX_WRITES(8), .STRICT_ORDER(1'b1)
   ) u_dut_s (
      .clk_core  (clk_core),
      .rst_core_n(rst_core_n),
      .trk       (if_s.slave)
   );

   hsv_core_mem_tracker #(
      .CNT_WIDTH(4), .MAX_READS(8), .MAX_WRITES(8), .STRICT_ORDER(1'b0)
   ) u_dut_r (
      .clk_core  (clk_core),
      .rst_core_n(rst_core_n),
      .trk       (if_r.slave)
   );

   initial clk_core = 1'b0;
   always #5 clk_core = ~clk_core;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_core);
      #1;
   endtask

   // One-cycle event pulse; the vector is {read_issue, read_done, write_issue, write_done, write_fwd}.
   task automatic pulse(input logic [4:0] ev);
      {read_issue, read_done, write_issue, write_done, write_fwd} = ev;
      tick();
      {read_issue, read_done, write_issue, write_done, write_fwd} = 5'b0;
   endtask

   localparam logic [4:0] EV_RI = 5'b10000;
   localparam logic [4:0] EV_RD = 5'b01000;
   localparam logic [4:0] EV_WI = 5'b00100;
   localparam logic [4:0] EV_WD = 5'b00010;
   localparam logic [4:0] EV_WF = 5'b00001;

   initial begin
      checks       = 0;
      failures     = 0;
      rst_core_n   = 1'b0;
      flush_req    = 1'b0;
      commit_write = 1'b0;
      {read_issue, read_done, write_issue, write_done, write_fwd} = 5'b0;

      // Reset values
      #3;
      chk("rst_flush", 32'(if_s.flush), 32'd1);
      chk("rst_ack", 32'(if_s.flush_ack), 32'd1);
      chk("rst_err", 32'(if_s.err), 32'd0);
      chk("rst_idle", 32'(if_s.idle), 32'd1);
      tick();
      tick();
      rst_core_n = 1'b1;
      #1;
      chk("rst_rel_flush", 32'(if_s.flush), 32'd1);
      tick();
      chk("run_flush", 32'(if_s.flush), 32'd0);
      chk("run_ack", 32'(if_s.flush_ack), 32'd0);
      chk("run_cir", 32'(if_s.can_issue_read), 32'd1);
      chk("run_pr", 32'(if_s.pending_reads), 32'd0);

      // Read limit
      for (int i = 0; i < 8; i++) pulse(EV_RI);
      chk("rd8_pr", 32'(if_s.pending_reads), 32'd8);
      chk("rd8_cir", 32'(if_s.can_issue_read), 32'd0);
      chk("rd8_idle", 32'(if_s.idle), 32'd0);
      pulse(EV_RD);
      chk("rd7_pr", 32'(if_s.pending_reads), 32'd7);
      chk("rd7_cir", 32'(if_s.can_issue_read), 32'd1);

      // Ordering: pending_reads=2, write_balance=1
      for (int i = 0; i < 5; i++) pulse(EV_RD);
      pulse(EV_WF);
      chk("ord_pr", 32'(if_s.pending_reads), 32'd2);
      chk("ord_bal", 32'(if_s.write_balance), 32'd1);
      chk("ord_s_ciw2", 32'(if_s.can_issue_write), 32'd0);
      chk("ord_r_ciw2", 32'(if_r.can_issue_write), 32'd1);
      pulse(EV_RD);
      chk("ord_s_ciw1", 32'(if_s.can_issue_write), 32'd0);
      pulse(EV_RD);
      chk("ord_s_cir0", 32'(if_s.can_issue_read), 32'd1);
      chk("ord_s_tie", 32'(if_s.can_issue_write), 32'd0);
      write_issue = 1'b1;
      #1;
      chk("ord_s_ciw0", 32'(if_s.can_issue_write), 32'd1);
      chk("ord_s_cir_wi", 32'(if_s.can_issue_read), 32'd0);
      tick();
      write_issue = 1'b0;
      chk("ord_pw", 32'(if_s.pending_writes), 32'd1);
      chk("ord_bal0", 32'(if_s.write_balance), 32'd0);

      // Balance going negative via commit_write permit
      chk("bal_ciw_nocw", 32'(if_s.can_issue_write), 32'd0);
      commit_write = 1'b1;
      #1;
      chk("bal_ciw_cw", 32'(if_s.can_issue_write), 32'd1);
      pulse(EV_WI);
      chk("bal_neg", 32'(if_s.write_balance), 32'hF);
      chk("bal_pw2", 32'(if_s.pending_writes), 32'd2);
      pulse(EV_WF);
      chk("bal_fwd0", 32'(if_s.write_balance), 32'd0);
      pulse(EV_WI);
      pulse(EV_WI | EV_WD | EV_WF);
      chk("bal_all_pw", 32'(if_s.pending_writes), 32'd3);
      chk("bal_all_bal", 32'(if_s.write_balance), 32'hF);
      chk("bal_r_pw", 32'(if_r.pending_writes), 32'd3);
      pulse(EV_WF);
      chk("bal_back0", 32'(if_s.write_balance), 32'd0);
      chk("pre_flush_err", 32'(if_s.err), 32'd0);

      // Flush with 3 writes in flight
      flush_req = 1'b1;
      tick();
      chk("drn_cir", 32'(if_s.can_issue_read), 32'd0);
      chk("drn_ciw", 32'(if_s.can_issue_write), 32'd0);
      chk("drn_flush", 32'(if_s.flush), 32'd0);
      pulse(EV_WD);
      pulse(EV_WD);
      chk("drn_pw1", 32'(if_s.pending_writes), 32'd1);
      chk("drn_flush1", 32'(if_s.flush), 32'd0);
      pulse(EV_WD);
      chk("drn_pw0", 32'(if_s.pending_writes), 32'd0);
      chk("drn_flush0", 32'(if_s.flush), 32'd0);
      tick();
      chk("fl_flush", 32'(if_s.flush), 32'd1);
      chk("fl_ack", 32'(if_s.flush_ack), 32'd0);
      tick();
      chk("hold_flush", 32'(if_s.flush), 32'd0);
      chk("hold_ack", 32'(if_s.flush_ack), 32'd1);
      tick();
      chk("hold_ack2", 32'(if_s.flush_ack), 32'd1);
      flush_req = 1'b0;
      tick();
      chk("rel_ack", 32'(if_s.flush_ack), 32'd0);
      chk("rel_idle", 32'(if_s.idle), 32'd1);
      commit_write = 1'b0;

      // Underflow sets sticky err; idle flush latency
      pulse(EV_RD);
      chk("uf_pr", 32'(if_s.pending_reads), 32'd0);
      chk("uf_err", 32'(if_s.err), 32'd1);
      flush_req = 1'b1;
      tick();
      chk("lat_drn_flush", 32'(if_s.flush), 32'd0);
      tick();
      chk("lat_flush", 32'(if_s.flush), 32'd1);
      tick();
      chk("lat_ack", 32'(if_s.flush_ack), 32'd1);
      flush_req = 1'b0;
      tick();
      chk("uf_err_sticky", 32'(if_s.err), 32'd1);

      // Reset during drain
      pulse(EV_RI);
      flush_req = 1'b1;
      tick();
      chk("mid_drn_pr", 32'(if_s.pending_reads), 32'd1);
      rst_core_n = 1'b0;
      #2;
      chk("mid_rst_flush", 32'(if_s.flush), 32'd1);
      chk("mid_rst_ack", 32'(if_s.flush_ack), 32'd1);
      chk("mid_rst_pr", 32'(if_s.pending_reads), 32'd0);
      chk("mid_rst_err", 32'(if_s.err), 32'd0);
      flush_req  = 1'b0;
      rst_core_n = 1'b1;
      tick();
      chk("mid_run_flush", 32'(if_s.flush), 32'd0);

      // Balance saturates at most-positive value
      for (int i = 0; i < 8; i++) pulse(EV_WF);
      chk("sat_bal", 32'(if_s.write_balance), 32'd7);
      chk("sat_err", 32'(if_s.err), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
